// File: rtl/des_ks_pkg.sv
// Shared DES key-schedule tables, FSM state type and bit-permutation helpers.
// Table entries use DES numbering: bit 1 is the MSB of the source vector.
package des_ks_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD_KEY = 2'd1,
        ST_RUN      = 2'd2
    } ks_state_t;

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT_TAB [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [55:0] pc1_perm(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[55-i] = k[64-PC1_TAB[i]];
        end
        return r;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] s);
        return (s == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] s);
        return (s == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

// File: rtl/des_ks_pc2.sv
// Permuted Choice 2: combinational 56-bit C/D to 48-bit round subkey.
module des_ks_pc2
    import des_ks_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] subkey
);

    logic unused_cd_bits;

    always_comb begin
        subkey = '0;
        for (int j = 0; j < 48; j++) begin
            subkey[47-j] = cd[56-PC2_TAB[j]];
        end
    end

    // PC2 drops eight C/D bits by design.
    assign unused_cd_bits = ^cd;

endmodule

// File: rtl/des_key_sched_seq.sv
// Sequential DES/TDES key scheduler emitting one subkey per handshake.
// Optional load-time key parity check: define DES_KS_PARITY_CHECK_EN.
module des_key_sched_seq
    import des_ks_pkg::*;
#(
    parameter int KEY_COUNT = 1,
    parameter int SK_W      = 48
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [64*KEY_COUNT-1:0] key,
    input  logic                    mode,
    input  logic                    key_valid,
    output logic                    key_ready,
    output logic [SK_W-1:0]         subkey,
    output logic                    sk_valid,
    input  logic                    sk_ready,
    output logic [3:0]              sk_round,
    output logic [1:0]              sk_key_idx,
    output logic                    sk_last,
    output logic                    par_err,
    output logic [1:0]              dbg_state
);

    if (SK_W != 48) begin : g_sk_w_chk
        $error("des_key_sched_seq: SK_W must be 48");
    end
    if (KEY_COUNT != 1 && KEY_COUNT != 3) begin : g_key_count_chk
        $error("des_key_sched_seq: KEY_COUNT must be 1 or 3");
    end

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // sk_valid never drops and the subkey fields never change until accepted.
    ks_state_t              state_q, state_d;
    logic [64*KEY_COUNT-1:0] key_q, key_d;
    logic                   mode_q, mode_d;
    logic [1:0]             pos_q, pos_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [55:0]            cd_q, cd_d;
    logic                   sk_valid_q, sk_valid_d;
    logic [47:0]            subkey_q, subkey_d;
    logic [3:0]             round_q, round_d;
    logic [1:0]             kidx_q, kidx_d;
    logic                   last_q, last_d;

    logic        accept, load_cd, issue, out_free, final_slot, slot_dec, par_bad;
    logic [1:0]  slot_idx, shamt;
    logic [3:0]  rnd;
    logic [63:0] slot_key;
    logic [27:0] c_rot, d_rot;
    logic [55:0] pc2_in;
    logic [47:0] pc2_out;
    logic        unused_key_par;

    assign out_free   = !sk_valid_q || sk_ready;
    assign final_slot = (pos_q == 2'(KEY_COUNT - 1));
    // Slot order alternates direction: E,D,E for mode 0 and D,E,D for mode 1.
    assign slot_dec   = mode_q ^ pos_q[0];
    assign slot_idx   = mode_q ? 2'(KEY_COUNT - 1) - pos_q : pos_q;
    assign rnd        = slot_dec ? 4'd15 - cnt_q[3:0] : cnt_q[3:0];
    assign shamt      = SHIFT_TAB[rnd];
    assign accept     = key_valid && key_ready;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (accept && !par_bad) state_d = ST_LOAD_KEY;
            ST_LOAD_KEY: if (load_cd) state_d = ST_RUN;
            ST_RUN: begin
                if (issue && cnt_q[3:0] == 4'd15 && !final_slot) state_d = ST_LOAD_KEY;
                else if (cnt_q[4] && sk_ready)                   state_d = ST_IDLE;
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs. LOAD_KEY waits for the previous slot's last subkey to drain.
    always_comb begin
        key_ready = 1'b0;
        load_cd   = 1'b0;
        issue     = 1'b0;
        case (state_q)
            ST_IDLE:     key_ready = 1'b1;
            ST_LOAD_KEY: load_cd   = out_free;
            ST_RUN:      issue     = !cnt_q[4] && out_free;
            default:     ;
        endcase
    end

    always_comb begin
        slot_key = key_q[63:0];
        for (int i = 0; i < KEY_COUNT; i++) begin
            if (slot_idx == 2'(i)) slot_key = key_q[64*i +: 64];
        end
    end

    // Encrypt rotates before emitting; decrypt emits then rotates right.
    always_comb begin
        if (slot_dec) begin
            c_rot  = rotr28(cd_q[55:28], shamt);
            d_rot  = rotr28(cd_q[27:0], shamt);
            pc2_in = cd_q;
        end else begin
            c_rot  = rotl28(cd_q[55:28], shamt);
            d_rot  = rotl28(cd_q[27:0], shamt);
            pc2_in = {c_rot, d_rot};
        end
    end

    des_ks_pc2 u_pc2 (
        .cd     (pc2_in),
        .subkey (pc2_out)
    );

    always_comb begin
        key_d      = key_q;
        mode_d     = mode_q;
        pos_d      = pos_q;
        cnt_d      = cnt_q;
        cd_d       = cd_q;
        sk_valid_d = sk_valid_q;
        subkey_d   = subkey_q;
        round_d    = round_q;
        kidx_d     = kidx_q;
        last_d     = last_q;
        if (accept) begin
            key_d  = key;
            mode_d = mode;
            pos_d  = 2'd0;
        end
        if (load_cd) begin
            cd_d  = pc1_perm(slot_key);
            cnt_d = 5'd0;
        end
        if (issue) begin
            cd_d       = {c_rot, d_rot};
            subkey_d   = pc2_out;
            round_d    = rnd;
            kidx_d     = slot_idx;
            last_d     = (cnt_q[3:0] == 4'd15) && final_slot;
            sk_valid_d = 1'b1;
            cnt_d      = cnt_q + 5'd1;
            if (cnt_q[3:0] == 4'd15 && !final_slot) pos_d = pos_q + 2'd1;
        end else if (sk_ready) begin
            sk_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q      <= '0;
            mode_q     <= 1'b0;
            pos_q      <= 2'd0;
            cnt_q      <= 5'd0;
            cd_q       <= '0;
            sk_valid_q <= 1'b0;
            subkey_q   <= '0;
            round_q    <= 4'd0;
            kidx_q     <= 2'd0;
            last_q     <= 1'b0;
        end else begin
            key_q      <= key_d;
            mode_q     <= mode_d;
            pos_q      <= pos_d;
            cnt_q      <= cnt_d;
            cd_q       <= cd_d;
            sk_valid_q <= sk_valid_d;
            subkey_q   <= subkey_d;
            round_q    <= round_d;
            kidx_q     <= kidx_d;
            last_q     <= last_d;
        end
    end

`ifdef DES_KS_PARITY_CHECK_EN
    logic par_err_q, par_err_d;

    always_comb begin
        par_bad = 1'b0;
        for (int i = 0; i < 8 * KEY_COUNT; i++) begin
            if (!(^key[8*i +: 8])) par_bad = 1'b1;
        end
    end

    assign par_err_d = accept && par_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_err_q <= 1'b0;
        else        par_err_q <= par_err_d;
    end

    assign par_err = par_err_q;
`else
    assign par_bad = 1'b0;
    assign par_err = 1'b0;
`endif

    // PC1 skips each byte's parity bit.
    assign unused_key_par = ^slot_key;

    assign subkey     = subkey_q;
    assign sk_valid   = sk_valid_q;
    assign sk_round   = round_q;
    assign sk_key_idx = kidx_q;
    assign sk_last    = last_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/des_key_sched_seq.md
DES_KEY_SCHED_SEQ -- requirements
Module: des_key_sched_seq

Interface
REQ-001 SHALL have parameter KEY_COUNT, default 1, number of 64-bit DES keys per load; legal values 1 or 3 (3 = TDES EDE).
REQ-002 SHALL have parameter SK_W, default 48, subkey width; fixed at 48, elaboration error otherwise.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port key  input  64*KEY_COUNT  raw keys; K1 = key[63:0], K2 = key[127:64], K3 = key[191:128].
REQ-006 SHALL have port mode  input  1  0 encrypt order, 1 decrypt order; sampled with key.
REQ-007 SHALL have port key_valid  input  1  key/mode present.
REQ-008 SHALL have port key_ready  output  1  block can accept a load.
REQ-009 SHALL have port subkey  output  48  current subkey (PC2 output).
REQ-010 SHALL have port sk_valid  output  1  subkey valid.
REQ-011 SHALL have port sk_ready  input  1  consumer accepts subkey.
REQ-012 SHALL have port sk_round  output  4  DES round number 1..16 of current subkey, encoded 0..15.
REQ-013 SHALL have port sk_key_idx  output  2  key slot (0..KEY_COUNT-1) of current subkey.
REQ-014 SHALL have port sk_last  output  1  high with the final subkey of the load.
REQ-015 SHALL have port par_err  output  1  one-cycle parity-error pulse.

Function
REQ-016 SHALL implement FSM IDLE -> LOAD_KEY -> RUN -> (LOAD_KEY | IDLE); key_ready = 1 only in IDLE.
REQ-017 SHALL accept a load on key_valid & key_ready; key, mode registered; key_valid ignored outside IDLE.
REQ-018 SHALL in LOAD_KEY apply PC1 to the current slot key into 28-bit C/D registers (one cycle).
REQ-019 SHALL rotate per round with shift table 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-020 SHALL, for an encrypt-direction key, produce round r from rotl(C,s_r)/rotl(D,s_r) of round r-1, emitting rounds 1..16.
REQ-021 SHALL, for a decrypt-direction key, emit round 16 from unrotated C0/D0, then rotr by s_r to obtain round r-1, emitting rounds 16..1.
REQ-022 SHALL hold subkey, sk_round, sk_key_idx, sk_last and C/D stable while sk_valid & !sk_ready; advance only on handshake.
REQ-023 SHALL give first sk_valid 2 cycles after the load handshake and, with sk_ready held 1, one subkey per cycle per key.
REQ-024 SHALL, for KEY_COUNT=3, sequence slots K1(E),K2(D),K3(E) when mode=0 and K3(D),K2(E),K1(D) when mode=1, with one LOAD_KEY bubble between slots.
REQ-025 SHALL assert sk_last only on the 16th subkey of the final slot; return to IDLE on its handshake, key_ready = 1 the next cycle.
REQ-026 SHALL compute rotations with 28-bit wrap-around (bit 27 to bit 0 for left, bit 0 to 27 for right).

Reset
REQ-027 SHALL on rst_n low, at any time including mid-RUN, force IDLE, sk_valid=0, key_ready=1 after release, subkey=0, sk_round=0, sk_key_idx=0, sk_last=0, par_err=0, C/D=0.
REQ-028 SHALL emit no partial sequence after reset; a new load restarts from round 1/16 of the first slot.

Configuration
REQ-029 SHALL with macro DES_KS_PARITY_CHECK_EN defined check odd parity of every key byte at load; on failure complete the handshake, pulse par_err one cycle, emit no subkeys, remain IDLE.
REQ-030 SHALL without DES_KS_PARITY_CHECK_EN ignore parity bits and tie par_err to 0.

Structure
REQ-031 SHALL place PC1 and PC2 tables, shift table, and the FSM state enum in package des_ks_pkg.
REQ-032 SHALL instantiate one sub-module des_ks_pc2 (56-bit C/D to 48-bit subkey, combinational) feeding the subkey register.

Verification
REQ-033 SHALL cover: KEY_COUNT=1, key 133457799BBCDFF1, mode 0, sk_ready=1 -> round 1 subkey 1B02EFFC7072 at 2 cycles post-load, round 16 CB3D8B0E17F5 with sk_last.
REQ-034 SHALL cover: same key, mode 1 -> first subkey CB3D8B0E17F5 (sk_round=15), last 1B02EFFC7072 (sk_round=0, sk_last=1).
REQ-035 SHALL cover: sk_ready toggled randomly -> 16 subkeys in order, outputs stable while stalled, none dropped or duplicated.
REQ-036 SHALL cover: KEY_COUNT=3, K1=K2=K3=133457799BBCDFF1, mode 0 -> 48 subkeys, slot 1 order reversed, sk_key_idx 0,1,2, one bubble per slot boundary.
REQ-037 SHALL cover: rst_n asserted at round 7 -> sk_valid=0 immediately, key_ready=1 after release, next load restarts at round 1.
REQ-038 SHALL cover: with DES_KS_PARITY_CHECK_EN, key 133457799BBCDFF0 -> par_err one-cycle pulse, sk_valid stays 0, key_ready=1 next cycle.
